// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 16-bit core.
// Optional macro ILLEGAL_TRAP_EN: reserved cls10 op 111 traps instead of retiring as a NOP.
module control_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        cond_true,
  output logic [15:0] ir_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        pc_we,
  output logic        pc_sel_branch,
  output logic        alu_src_imm,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic        wb_sel_mem,
  output logic        flags_we,
  output logic        retire,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RFN = 2'b10;
  localparam logic [1:0] ALU_SHF = 2'b11;
  // Counter value seen on the last permitted waiting cycle.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] cls;
  logic       is_ldr, is_str, is_imm_alu, is_subi, is_rtype, is_shift;
  logic       is_branch, is_cmp;

  assign cls        = ir_q[15:14];
  assign is_ldr     = (cls == 2'b00) && (ir_q[13:12] == 2'b00);
  assign is_str     = (cls == 2'b00) && (ir_q[13:12] == 2'b01);
  assign is_imm_alu = (cls == 2'b00) && ir_q[13];
  assign is_subi    = ir_q[12];
  assign is_rtype   = (cls == 2'b01);
  assign is_shift   = (cls == 2'b11);
  assign is_branch  = (cls == 2'b10) && (ir_q[13:11] <= 3'b100);
  assign is_cmp     = (cls == 2'b10) && ((ir_q[13:11] == 3'b101) || (ir_q[13:11] == 3'b110));

  assign ir_out = ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    cnt_d         = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    pc_we         = 1'b0;
    pc_sel_branch = 1'b0;
    alu_src_imm   = 1'b0;
    alu_op        = ALU_ADD;
    reg_we        = 1'b0;
    wb_sel_mem    = 1'b0;
    flags_we      = 1'b0;
    retire        = 1'b0;
    fault         = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_ldr || is_str) begin
          alu_src_imm = 1'b1;
          state_d     = S_MEM;
        end else if (is_imm_alu) begin
          alu_src_imm = 1'b1;
          alu_op      = is_subi ? ALU_SUB : ALU_ADD;
          state_d     = S_WB;
        end else if (is_rtype) begin
          alu_op  = ALU_RFN;
          state_d = S_WB;
        end else if (is_shift) begin
          alu_src_imm = 1'b1;
          alu_op      = ALU_SHF;
          state_d     = S_WB;
        end else if (is_branch) begin
          pc_we         = cond_true;
          pc_sel_branch = 1'b1;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end else if (is_cmp) begin
          alu_src_imm = 1'b1;
          alu_op      = ALU_SUB;
          flags_we    = 1'b1;
          retire      = 1'b1;
          state_d     = S_FETCH;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          retire  = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_str;
        if (mem_ready) begin
          if (is_ldr) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        wb_sel_mem = is_ldr;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  fault = 1'b1;
`endif
      default: state_d = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer; strobes are packed into one word per check.
module tb_control_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        cond_true;
  logic [15:0] ir_out;
  logic        mem_req, mem_we, mem_addr_sel, pc_we, pc_sel_branch, alu_src_imm;
  logic [1:0]  alu_op;
  logic        reg_we, wb_sel_mem, flags_we, retire, fault;

  int n_assert;
  int n_fail;

  control_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cond_true(cond_true), .ir_out(ir_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .pc_we(pc_we), .pc_sel_branch(pc_sel_branch),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel_mem(wb_sel_mem), .flags_we(flags_we), .retire(retire), .fault(fault)
  );

  localparam logic [15:0] REQ   = 16'h1000;
  localparam logic [15:0] WE    = 16'h0800;
  localparam logic [15:0] ASEL  = 16'h0400;
  localparam logic [15:0] PCWE  = 16'h0200;
  localparam logic [15:0] PCBR  = 16'h0100;
  localparam logic [15:0] IMM   = 16'h0080;
  localparam logic [15:0] OPSUB = 16'h0020;
  localparam logic [15:0] OPR   = 16'h0040;
  localparam logic [15:0] OPSH  = 16'h0060;
  localparam logic [15:0] REGWE = 16'h0010;
  localparam logic [15:0] WBM   = 16'h0008;
  localparam logic [15:0] FLG   = 16'h0004;
  localparam logic [15:0] RET   = 16'h0002;
  localparam logic [15:0] FLT   = 16'h0001;

  logic [15:0] strb;
  assign strb = {3'b000, mem_req, mem_we, mem_addr_sel, pc_we, pc_sel_branch,
                 alu_src_imm, alu_op, reg_we, wb_sel_mem, flags_we, retire, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake an instruction in FETCH, then land in DECODE.
  task automatic fetch(input logic [15:0] instr, input string tag);
    mem_rdata = instr;
    mem_ready = 1'b1;
    #1;
    chk({tag, "_fetch"}, strb, REQ | PCWE);
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'hDEAD;
    #1;
    chk({tag, "_ir"}, ir_out, instr);
    chk({tag, "_decode"}, strb, 16'h0000);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    cond_true = 1'b0;
    #12;
    chk("reset_strobes", strb, 16'h0000);
    chk("reset_ir", ir_out, 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("rst_state", strb, 16'h0000);
    tick();
    chk("first_fetch", strb, REQ);

    // ADDI: retire in cycle 4
    fetch(16'h2005, "addi");
    tick(); chk("addi_exec", strb, IMM);
    tick(); chk("addi_wb", strb, REGWE | RET);
    tick(); chk("addi_next", strb, REQ);

    // LDR with 3 wait cycles on the data access
    fetch(16'h0003, "ldr");
    tick(); chk("ldr_exec", strb, IMM);
    tick(); chk("ldr_wait1", strb, REQ | ASEL);
    tick(); chk("ldr_wait2", strb, REQ | ASEL);
    tick(); chk("ldr_wait3", strb, REQ | ASEL);
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    #1;
    chk("ldr_ready", strb, REQ | ASEL);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("ldr_wb", strb, REGWE | WBM | RET);
    chk("ldr_ir_kept", ir_out, 16'h0003);
    tick(); chk("ldr_next", strb, REQ);

    // STR, zero-wait
    fetch(16'h1003, "str");
    tick(); chk("str_exec", strb, IMM);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("str_mem", strb, REQ | WE | ASEL | RET);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("str_next", strb, REQ);

    fetch(16'h3007, "subi");
    tick(); chk("subi_exec", strb, IMM | OPSUB);
    tick(); chk("subi_wb", strb, REGWE | RET);
    tick();

    fetch(16'h4123, "rtype");
    tick(); chk("rtype_exec", strb, OPR);
    tick(); chk("rtype_wb", strb, REGWE | RET);
    tick();

    fetch(16'hC001, "shift");
    tick(); chk("shift_exec", strb, IMM | OPSH);
    tick(); chk("shift_wb", strb, REGWE | RET);
    tick();

    // Branch taken / not taken
    fetch(16'h8004, "br_t");
    tick();
    cond_true = 1'b1;
    #1;
    chk("br_taken_exec", strb, PCWE | PCBR | RET);
    tick();
    cond_true = 1'b0;
    #1;
    chk("br_taken_next", strb, REQ);
    fetch(16'h8004, "br_n");
    tick(); chk("br_not_exec", strb, PCBR | RET);
    tick(); chk("br_not_next", strb, REQ);

    fetch(16'hA805, "cmp");
    tick(); chk("cmp_exec", strb, IMM | OPSUB | FLG | RET);
    tick(); chk("cmp_next", strb, REQ);
    fetch(16'hB005, "ucmp");
    tick(); chk("ucmp_exec", strb, IMM | OPSUB | FLG | RET);
    tick(); chk("ucmp_fetch1", strb, REQ);

    // mem_ready on the last allowed waiting cycle beats the timeout
    repeat (15) tick();
    chk("limit_wait16", strb, REQ);
    mem_rdata = 16'h2005;
    mem_ready = 1'b1;
    #1;
    chk("limit_ready", strb, REQ | PCWE);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("limit_decode", strb, 16'h0000);
    tick(); tick(); tick();
    chk("limit_back_fetch", strb, REQ);

    // Reset mid-request drops mem_req at once and clears IR
    mem_rdata = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreq_strobes", strb, 16'h0000);
    chk("midreq_ir", ir_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midreq_refetch", strb, REQ);

    // Reserved cls10 op 111
    fetch(16'hB800, "resv");
    tick();
`ifdef ILLEGAL_TRAP_EN
    chk("resv_exec", strb, 16'h0000);
    tick(); chk("trap", strb, FLT);
    mem_ready = 1'b1;
    tick(); tick();
    chk("trap_held", strb, FLT);
    mem_ready = 1'b0;
`else
    chk("resv_exec", strb, RET);
    tick(); chk("resv_next", strb, REQ);
`endif
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("pre_timeout_fetch", strb, REQ);

    // Fetch timeout after 16 waiting cycles
    repeat (15) tick();
    chk("timeout_wait16", strb, REQ);
    tick(); chk("timeout_fault", strb, FLT);
    mem_ready = 1'b1;
    tick(); chk("fault_sticky", strb, FLT);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("fault_reset", strb, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("fault_rst_state", strb, 16'h0000);
    tick(); chk("fault_refetch", strb, REQ);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
